dram_arbiter: RTL and testbench
===============================

# dram_arbiter

Two-port arbiter that shares the single-ported data RAM between the CPU memory stage (port 0) and the program/data loader (port 1). It takes word-level read/write requests over a valid/ready handshake and grants at most one per cycle, round-robin or CPU-priority. It drives the RAM address, write data and write enable, and returns read data through a registered response slot per port. Byte-lane merging stays in the existing byte-control logic upstream of port 0; this block only handles whole words.

## Interface
Parameters:
- `DW`, 32, data width (matches `datawidth`)
- `AW`, 8, RAM word-address width (matches `addrwidth`)
- `CPU_PRIORITY`, 0, 1 = port 0 always wins conflicts; 0 = round-robin

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `p0_req_valid`, `p1_req_valid`  in  1  request present
- `p0_req_we`, `p1_req_we`  in  1  1 = write, 0 = read
- `p0_req_addr`, `p1_req_addr`  in  AW  word address
- `p0_req_wdata`, `p1_req_wdata`  in  DW  write data
- `p0_req_ready`, `p1_req_ready`  out  1  request accepted this cycle (combinational)
- `p0_rsp_valid`, `p1_rsp_valid`  out  1  read data held in the response slot
- `p0_rsp_rdata`, `p1_rsp_rdata`  out  DW  read data
- `p0_rsp_ready`, `p1_rsp_ready`  in  1  consumer takes the response
- `ram_addr`  out  AW  RAM word address
- `ram_wdata`  out  DW  RAM write data
- `ram_we`  out  1  RAM write enable
- `ram_rdata`  in  DW  RAM read data, valid the cycle after the address is presented
- `conflict_cnt`  out  16  saturating count of cycles in which both ports were eligible

## Operation
- Eligibility:
  - A write is eligible whenever its valid is high.
  - A read on port p is eligible only if no read for p is in flight and p's response slot is empty, or is being consumed this cycle (`rsp_valid & rsp_ready`).
- Grant: at most one per cycle.
  - One port eligible: that port is granted.
  - Both eligible, `CPU_PRIORITY=1`: port 0 is granted.
  - Both eligible, `CPU_PRIORITY=0`: the port that is not `last_grant` is granted. `last_grant` updates on every grant.
- `req_ready` is high only for the granted port. Acceptance = `req_valid & req_ready`.
- RAM drive:
  - `ram_addr`, `ram_wdata` and `ram_we` (= granted & we) come from the granted request in the same cycle.
  - With no grant: `ram_we = 0`, and `ram_addr` / `ram_wdata` hold their last values (registered mux select).
- In-flight stage: registers `s1_valid`, `s1_port` and `s1_read` for the granted request.
- Response capture: when `s1_valid & s1_read`, `ram_rdata` is loaded into the slot for `s1_port` at the end of that cycle, and that port's `rsp_valid` is set.
- Response release: the slot clears on `rsp_valid & rsp_ready`. Capture and release in the same cycle on one port is impossible by the eligibility rule.
- Ordering:
  - A write accepted in cycle N is visible to any read accepted in N+1 or later, on either port.
  - Responses on one port return in request order, since only one read per port is outstanding.
- `conflict_cnt` increments on every cycle in which both ports were eligible and saturates at 0xFFFF.
- Reset values:
  - All `req_ready` = 0, `ram_we` = 0 while `rst` is high.
  - `ram_addr` = 0, `ram_wdata` = 0.
  - `rsp_valid` = 0, `rsp_rdata` = 0, `s1_valid` = 0.
  - `last_grant` = 1, so port 0 wins the first conflict.
  - `conflict_cnt` = 0.
- Reset mid-operation: an in-flight read is dropped with no response, a held response is discarded, and a write presented in the reset cycle is not performed.

## Timing
- Write: accepted in cycle N, RAM updated at the rising edge ending N. Back-to-back writes at 1 per cycle.
- Read: accepted in cycle N, `ram_rdata` valid in N+1, `rsp_valid` high from N+2.
- Per-port read throughput with `rsp_ready` tied high: one read every 2 cycles. The next read on that port is eligible in N+2, the cycle its response is consumed.
- Two ports alternating reads under round-robin: one grant per cycle, with RAM fully utilized.
- A starved port waits at most 1 cycle under round-robin. Under `CPU_PRIORITY=1`, port 1 can starve indefinitely; this is intended during CPU run.

## Test plan
- Reset: hold `rst` 3 cycles with both ports requesting. Required: all `req_ready`, `ram_we` and `rsp_valid` stay 0 and `conflict_cnt` stays 0. After release, port 0 is granted first.
- Write/read: port 1 writes 0xDEADBEEF to addr 0x10 in cycle N. Port 0 reads 0x10 in N+1. Required: `p0_rsp_valid` in N+3 with `p0_rsp_rdata` = 0xDEADBEEF.
- Round-robin: both ports issue continuous writes to addrs 0x00..0x07 for 8 cycles. Required: grants alternate 0,1,0,1,… and `conflict_cnt` = 8.
- Priority: repeat the previous scenario with `CPU_PRIORITY=1`. Required: port 0 is granted all 8 cycles and port 1 gets none until port 0's valid drops.
- Backpressure: port 0 reads addr 0x20 (holding 0x12345678) with `p0_rsp_ready` = 0. Required: `p0_rsp_valid` stays high with stable data, a second port 0 read is not granted, and port 1 is granted meanwhile. Raising `p0_rsp_ready` for 1 cycle allows the second read in that same cycle.
- Reset mid-read: assert `rst` in the cycle after a read acceptance. Required: no `rsp_valid` pulse ever follows, and the first post-reset request is serviced normally.

Source files
------------

// File: rtl/dram_arbiter.sv
// Two-port word arbiter in front of the single-ported data RAM: CPU memory stage on
// port 0, loader on port 1, round-robin or CPU-priority, one grant per cycle.
module dram_arbiter #(
  parameter int unsigned DW           = 32,
  parameter int unsigned AW           = 8,
  parameter bit          CPU_PRIORITY = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req_valid,
  input  logic          p0_req_we,
  input  logic [AW-1:0] p0_req_addr,
  input  logic [DW-1:0] p0_req_wdata,
  output logic          p0_req_ready,
  input  logic          p1_req_valid,
  input  logic          p1_req_we,
  input  logic [AW-1:0] p1_req_addr,
  input  logic [DW-1:0] p1_req_wdata,
  output logic          p1_req_ready,
  output logic          p0_rsp_valid,
  output logic [DW-1:0] p0_rsp_rdata,
  input  logic          p0_rsp_ready,
  output logic          p1_rsp_valid,
  output logic [DW-1:0] p1_rsp_rdata,
  input  logic          p1_rsp_ready,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata,
  output logic [15:0]   conflict_cnt
);

  logic          s1_valid;
  logic          s1_port;
  logic          s1_read;
  logic          last_grant;
  logic [AW-1:0] addr_hold;
  logic [DW-1:0] wdata_hold;
  logic          rd_busy0, rd_busy1;
  logic          elig0, elig1, both_elig;
  logic          gnt0, gnt1;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A read may only issue once the port's slot is free (or freed this cycle),
  // which keeps exactly one read outstanding per port and responses in order.
  assign rd_busy0  = s1_valid & s1_read & ~s1_port;
  assign rd_busy1  = s1_valid & s1_read &  s1_port;
  assign elig0     = ~rst & p0_req_valid &
                     (p0_req_we | (~rd_busy0 & (~p0_rsp_valid | p0_rsp_ready)));
  assign elig1     = ~rst & p1_req_valid &
                     (p1_req_we | (~rd_busy1 & (~p1_rsp_valid | p1_rsp_ready)));
  assign both_elig = elig0 & elig1;

  assign gnt0 = elig0 & (~elig1 | CPU_PRIORITY | last_grant);
  assign gnt1 = elig1 & ~gnt0;

  assign p0_req_ready = gnt0;
  assign p1_req_ready = gnt1;

  // RAM drive comes straight from the winner; idle cycles replay the last address/data.
  always_comb begin
    ram_addr  = addr_hold;
    ram_wdata = wdata_hold;
    ram_we    = 1'b0;
    if (gnt0) begin
      ram_addr  = p0_req_addr;
      ram_wdata = p0_req_wdata;
      ram_we    = p0_req_we;
    end else if (gnt1) begin
      ram_addr  = p1_req_addr;
      ram_wdata = p1_req_wdata;
      ram_we    = p1_req_we;
    end
  end

  // Grant stage -> in-flight stage
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_port      <= 1'b0;
      s1_read      <= 1'b0;
      last_grant   <= 1'b1;
      conflict_cnt <= 16'd0;
      addr_hold    <= '0;
      wdata_hold   <= '0;
    end else begin
      s1_valid   <= gnt0 | gnt1;
      s1_port    <= gnt1;
      s1_read    <= (gnt0 & ~p0_req_we) | (gnt1 & ~p1_req_we);
      addr_hold  <= ram_addr;
      wdata_hold <= ram_wdata;
      if (gnt0 | gnt1) last_grant <= gnt1;
      if (both_elig) conflict_cnt <= sat_inc(conflict_cnt);
    end
  end

  // In-flight stage -> response slots
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_rsp_valid <= 1'b0;
      p0_rsp_rdata <= '0;
    end else if (rd_busy0) begin
      p0_rsp_valid <= 1'b1;
      p0_rsp_rdata <= ram_rdata;
    end else if (p0_rsp_valid & p0_rsp_ready) begin
      p0_rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_rsp_valid <= 1'b0;
      p1_rsp_rdata <= '0;
    end else if (rd_busy1) begin
      p1_rsp_valid <= 1'b1;
      p1_rsp_rdata <= ram_rdata;
    end else if (p1_rsp_valid & p1_rsp_ready) begin
      p1_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: a round-robin and a CPU-priority instance share one stimulus
// stream; a transaction-level model of both is compared against them every cycle.
module tb_dram_arbiter;
  localparam int DW = 32;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          p0_req_valid, p0_req_we, p1_req_valid, p1_req_we;
  logic [AW-1:0] p0_req_addr, p1_req_addr;
  logic [DW-1:0] p0_req_wdata, p1_req_wdata;
  logic          p0_rsp_ready, p1_rsp_ready;

  logic          p0_req_ready [2];
  logic          p1_req_ready [2];
  logic          p0_rsp_valid [2];
  logic          p1_rsp_valid [2];
  logic [DW-1:0] p0_rsp_rdata [2];
  logic [DW-1:0] p1_rsp_rdata [2];
  logic [AW-1:0] ram_addr     [2];
  logic [DW-1:0] ram_wdata    [2];
  logic          ram_we       [2];
  logic [DW-1:0] ram_rdata    [2];
  logic [15:0]   conflict_cnt [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return {{(DW-AW){1'b0}}, a} ^ 32'hA5C3_0000;
  endfunction

  // Instance 0: round-robin, instance 1: CPU priority; each with its own RAM.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [DW-1:0] ram_mem [256];
    initial for (int a = 0; a < 256; a++) ram_mem[a] = init_word(a[AW-1:0]);
    always @(posedge clk) begin
      ram_rdata[g] <= ram_mem[ram_addr[g]];
      if (ram_we[g]) ram_mem[ram_addr[g]] = ram_wdata[g];
    end
    dram_arbiter #(.DW(DW), .AW(AW), .CPU_PRIORITY(g == 1)) u_dut (
      .clk(clk), .rst(rst),
      .p0_req_valid(p0_req_valid), .p0_req_we(p0_req_we),
      .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_ready(p0_req_ready[g]),
      .p1_req_valid(p1_req_valid), .p1_req_we(p1_req_we),
      .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_ready(p1_req_ready[g]),
      .p0_rsp_valid(p0_rsp_valid[g]), .p0_rsp_rdata(p0_rsp_rdata[g]), .p0_rsp_ready(p0_rsp_ready),
      .p1_rsp_valid(p1_rsp_valid[g]), .p1_rsp_rdata(p1_rsp_rdata[g]), .p1_rsp_ready(p1_rsp_ready),
      .ram_addr(ram_addr[g]), .ram_wdata(ram_wdata[g]), .ram_we(ram_we[g]),
      .ram_rdata(ram_rdata[g]), .conflict_cnt(conflict_cnt[g])
    );
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- transaction-level model ----------------
  logic [DW-1:0] ref_mem     [2][256];
  bit            m_inflight  [2][2];
  logic [DW-1:0] m_infl_data [2][2];
  bit            m_slot      [2][2];
  logic [DW-1:0] m_slot_data [2][2];
  int            m_last      [2];
  int            m_cnt       [2];
  logic [AW-1:0] m_addr      [2];
  logic [DW-1:0] m_wdata     [2];

  bit            vv [2], ww [2], rr [2], el [2], gg [2];
  logic [AW-1:0] aa [2];
  logic [DW-1:0] dd [2];
  bit            both, exp_we;
  int            win;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wd;

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 256; a++) ref_mem[i][a] = init_word(a[AW-1:0]);
      m_last[i] = 1; m_cnt[i] = 0; m_addr[i] = '0; m_wdata[i] = '0;
      for (int p = 0; p < 2; p++) begin
        m_inflight[i][p] = 0; m_slot[i][p] = 0;
        m_infl_data[i][p] = '0; m_slot_data[i][p] = '0;
      end
    end
  end

  always @(negedge clk) begin
    vv[0] = p0_req_valid; ww[0] = p0_req_we; aa[0] = p0_req_addr; dd[0] = p0_req_wdata; rr[0] = p0_rsp_ready;
    vv[1] = p1_req_valid; ww[1] = p1_req_we; aa[1] = p1_req_addr; dd[1] = p1_req_wdata; rr[1] = p1_rsp_ready;
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++)
        el[p] = !rst && vv[p] && (ww[p] || (!m_inflight[i][p] && (!m_slot[i][p] || rr[p])));
      both = el[0] && el[1];
      if (both) win = (i == 1) ? 0 : 1 - m_last[i];
      else      win = el[0] ? 0 : 1;
      gg[0] = el[0] && win == 0;
      gg[1] = el[1] && win == 1;
      exp_we = 0; exp_addr = m_addr[i]; exp_wd = m_wdata[i];
      for (int p = 0; p < 2; p++)
        if (gg[p]) begin exp_we = ww[p]; exp_addr = aa[p]; exp_wd = dd[p]; end

      if (cyc > 0) begin
        chk($sformatf("i%0d p0_req_ready", i), p0_req_ready[i], gg[0]);
        chk($sformatf("i%0d p1_req_ready", i), p1_req_ready[i], gg[1]);
        chk($sformatf("i%0d ram_we", i), ram_we[i], exp_we);
        chk($sformatf("i%0d ram_addr", i), ram_addr[i], exp_addr);
        chk($sformatf("i%0d ram_wdata", i), ram_wdata[i], exp_wd);
        chk($sformatf("i%0d p0_rsp_valid", i), p0_rsp_valid[i], m_slot[i][0]);
        chk($sformatf("i%0d p1_rsp_valid", i), p1_rsp_valid[i], m_slot[i][1]);
        if (m_slot[i][0]) chk($sformatf("i%0d p0_rsp_rdata", i), p0_rsp_rdata[i], m_slot_data[i][0]);
        if (m_slot[i][1]) chk($sformatf("i%0d p1_rsp_rdata", i), p1_rsp_rdata[i], m_slot_data[i][1]);
        chk($sformatf("i%0d conflict_cnt", i), conflict_cnt[i], m_cnt[i]);
      end

      if (rst) begin
        for (int p = 0; p < 2; p++) begin m_inflight[i][p] = 0; m_slot[i][p] = 0; end
        m_last[i] = 1; m_cnt[i] = 0; m_addr[i] = '0; m_wdata[i] = '0;
      end else begin
        m_addr[i] = exp_addr; m_wdata[i] = exp_wd;
        for (int p = 0; p < 2; p++) begin
          if (m_slot[i][p] && rr[p]) m_slot[i][p] = 0;
          if (m_inflight[i][p]) begin
            m_slot[i][p] = 1; m_slot_data[i][p] = m_infl_data[i][p]; m_inflight[i][p] = 0;
          end
          if (gg[p]) begin
            if (ww[p]) ref_mem[i][aa[p]] = dd[p];
            else begin m_inflight[i][p] = 1; m_infl_data[i][p] = ref_mem[i][aa[p]]; end
            m_last[i] = p;
          end
        end
        if (both && m_cnt[i] < 65535) m_cnt[i]++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(); @(posedge clk); #1; endtask
  task automatic idle(); p0_req_valid = 0; p1_req_valid = 0; endtask
  task automatic req0(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p0_req_valid = 1; p0_req_we = we; p0_req_addr = a; p0_req_wdata = d;
  endtask
  task automatic req1(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p1_req_valid = 1; p1_req_we = we; p1_req_addr = a; p1_req_wdata = d;
  endtask

  initial begin
    idle(); p0_req_we = 0; p1_req_we = 0; p0_req_addr = '0; p1_req_addr = '0;
    p0_req_wdata = '0; p1_req_wdata = '0; p0_rsp_ready = 1; p1_rsp_ready = 1;

    // Reset held 3 cycles with both ports requesting
    rst = 1; req0(1, 8'h01, 32'h1111); req1(1, 8'h02, 32'h2222);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk("rst p0_ready", p0_req_ready[0], 0);
        chk("rst ram_we", ram_we[0], 0);
        chk("rst ram_addr", ram_addr[0], 0);
        chk("rst conflict_cnt", conflict_cnt[0], 0);
        chk("rst p0_rsp_valid", p0_rsp_valid[0], 0);
      end
      step();
    end
    rst = 0;
    @(negedge clk);
    chk("first grant rr p0", p0_req_ready[0], 1);
    chk("first grant rr p1", p1_req_ready[0], 0);
    chk("first grant prio p0", p0_req_ready[1], 1);
    step(); idle();

    // Loader writes, CPU reads the same word the next cycle
    req1(1, 8'h10, 32'hDEADBEEF);
    @(negedge clk); chk("wr p1_ready", p1_req_ready[0], 1); step();
    idle(); req0(0, 8'h10, '0);
    @(negedge clk); chk("rd p0_ready", p0_req_ready[0], 1); step();
    idle();
    @(negedge clk); chk("rd N+2 rsp_valid", p0_rsp_valid[0], 0); step();
    @(negedge clk);
    chk("rd N+3 rsp_valid", p0_rsp_valid[0], 1);
    chk("rd N+3 rsp_rdata", p0_rsp_rdata[0], 32'hDEADBEEF);
    step();

    // Continuous writes from both ports: alternation vs. priority
    rst = 1; step(); rst = 0;
    for (int k = 0; k < 8; k++) begin
      req0(1, AW'(k), 32'h1000 + k); req1(1, AW'(k), 32'h2000 + k);
      @(negedge clk);
      chk($sformatf("rr%0d p0", k), p0_req_ready[0], (k % 2) == 0);
      chk($sformatf("rr%0d p1", k), p1_req_ready[0], (k % 2) == 1);
      chk($sformatf("prio%0d p0", k), p0_req_ready[1], 1);
      chk($sformatf("prio%0d p1", k), p1_req_ready[1], 0);
      step();
    end
    p0_req_valid = 0;
    @(negedge clk);
    chk("rr conflict_cnt", conflict_cnt[0], 8);
    chk("prio conflict_cnt", conflict_cnt[1], 8);
    chk("prio p1 after p0 drops", p1_req_ready[1], 1);
    step(); idle();

    // Backpressure on port 0's response slot
    req1(1, 8'h20, 32'h12345678); @(negedge clk); step();
    idle(); p0_rsp_ready = 0; req0(0, 8'h20, '0);
    @(negedge clk); chk("bp rd accept", p0_req_ready[0], 1); step();
    idle(); @(negedge clk); step();
    for (int k = 0; k < 3; k++) begin
      req0(0, 8'h21, '0); req1(1, AW'(8'h30 + k), DW'(k));
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("bp%0d i%0d rsp_valid", k, i), p0_rsp_valid[i], 1);
        chk($sformatf("bp%0d i%0d rsp_rdata", k, i), p0_rsp_rdata[i], 32'h12345678);
        chk($sformatf("bp%0d i%0d p0_ready", k, i), p0_req_ready[i], 0);
        chk($sformatf("bp%0d i%0d p1_ready", k, i), p1_req_ready[i], 1);
      end
      step();
    end
    p1_req_valid = 0; p0_rsp_ready = 1;
    @(negedge clk);
    chk("bp release rr p0_ready", p0_req_ready[0], 1);
    chk("bp release prio p0_ready", p0_req_ready[1], 1);
    step();
    p0_rsp_ready = 0; idle(); @(negedge clk); step();
    @(negedge clk); chk("bp second rdata", p0_rsp_rdata[0], init_word(8'h21)); step();
    p0_rsp_ready = 1; @(negedge clk); step();

    // Reset in the cycle after a read acceptance
    req0(0, 8'h10, '0);
    @(negedge clk); chk("rstrd accept", p0_req_ready[0], 1); step();
    idle(); rst = 1; @(negedge clk); step(); rst = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("rstrd%0d rr rsp_valid", k), p0_rsp_valid[0], 0);
      chk($sformatf("rstrd%0d prio rsp_valid", k), p0_rsp_valid[1], 0);
      step();
    end
    req0(0, 8'h20, '0);
    @(negedge clk); chk("post-rst accept", p0_req_ready[0], 1); step();
    idle(); @(negedge clk); step();
    @(negedge clk);
    chk("post-rst rsp_valid", p0_rsp_valid[0], 1);
    chk("post-rst rsp_rdata", p0_rsp_rdata[0], 32'h12345678);
    step();

    // Randomized traffic, including occasional resets
    for (int k = 0; k < 3000; k++) begin
      rst          = ($urandom_range(0, 149) == 0);
      p0_req_valid = ($urandom_range(0, 3) != 0);
      p1_req_valid = ($urandom_range(0, 3) != 0);
      p0_req_we    = $urandom_range(0, 1);
      p1_req_we    = $urandom_range(0, 1);
      p0_req_addr  = AW'($urandom_range(0, 15));
      p1_req_addr  = AW'($urandom_range(0, 15));
      p0_req_wdata = $urandom;
      p1_req_wdata = $urandom;
      p0_rsp_ready = ($urandom_range(0, 9) < 7);
      p1_rsp_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    rst = 0; idle(); p0_rsp_ready = 1; p1_rsp_ready = 1;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
